// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU/memory encodings and the micro-op bundle.
// pc and imm are held at the widest XLEN; narrower builds use the low bits.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS   = 2'b11
    } alu_op_e;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        logic                has_imm;
        logic                reg_write;
        logic                alu_src;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        alu_op_e             alu_op;
        logic [1:0]          mem_size;
        logic                illegal;
    } uop_t;

endpackage

// File: rtl/uop_decoder.sv
// Combinational RV32I/RV64I decoder: raw instruction and PC to a micro-op.
// Immediates are sign-extended to the full bundle width.
module uop_decoder
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output uop_t            uop
);

    logic [XLEN_MAX-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [2:0]          f3;
    logic                sz_bad;
    logic                ld_wide;
    logic                legal;

    assign f3      = instr[14:12];
    assign sz_bad  = (f3[1:0] == 2'b11);
    assign ld_wide = (XLEN == 64) && (f3 == 3'b011);

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};

    // Per-opcode field selection, control generation and legality
    always_comb begin
        uop        = '0;
        legal      = (instr[1:0] == 2'b11);
        uop.pc     = XLEN_MAX'(pc);
        uop.opcode = instr[6:0];
        uop.funct3 = f3;
        uop.funct7 = instr[31:25];
        uop.rs1    = instr[19:15];
        uop.rs2    = instr[24:20];
        uop.rd     = instr[11:7];
        unique case (1'b1)
            instr[6:0] == OP_R: begin
                uop.reg_write = 1'b1;
                uop.alu_op    = ALU_FUNCT;
            end
            instr[6:0] == OP_IMM: begin
                uop.has_imm   = 1'b1;
                uop.reg_write = 1'b1;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_FUNCT;
                uop.rs2       = '0;
                uop.imm       = imm_i;
            end
            instr[6:0] == OP_LOAD: begin
                uop.has_imm    = 1'b1;
                uop.reg_write  = 1'b1;
                uop.alu_src    = 1'b1;
                uop.mem_read   = 1'b1;
                uop.mem_to_reg = 1'b1;
                uop.alu_op     = ALU_ADD;
                uop.rs2        = '0;
                uop.imm        = imm_i;
                uop.mem_size   = f3[1:0];
                if (sz_bad && !ld_wide) legal = 1'b0;
            end
            instr[6:0] == OP_STORE: begin
                uop.has_imm   = 1'b1;
                uop.alu_src   = 1'b1;
                uop.mem_write = 1'b1;
                uop.alu_op    = ALU_ADD;
                uop.rd        = '0;
                uop.imm       = imm_s;
                uop.mem_size  = f3[1:0];
                if (sz_bad) legal = 1'b0;
            end
            instr[6:0] == OP_BRANCH: begin
                uop.has_imm = 1'b1;
                uop.branch  = 1'b1;
                uop.alu_op  = ALU_BRANCH;
                uop.rd      = '0;
                uop.imm     = imm_b;
            end
            instr[6:0] == OP_JAL: begin
                uop.has_imm   = 1'b1;
                uop.reg_write = 1'b1;
                uop.branch    = 1'b1;
                uop.alu_op    = ALU_ADD;
                uop.rs1       = '0;
                uop.rs2       = '0;
                uop.imm       = imm_j;
            end
            instr[6:0] == OP_JALR: begin
                uop.has_imm   = 1'b1;
                uop.reg_write = 1'b1;
                uop.alu_src   = 1'b1;
                uop.branch    = 1'b1;
                uop.alu_op    = ALU_ADD;
                uop.rs2       = '0;
                uop.imm       = imm_i;
            end
            instr[6:0] == OP_LUI: begin
                uop.has_imm   = 1'b1;
                uop.reg_write = 1'b1;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_PASS;
                uop.rs1       = '0;
                uop.rs2       = '0;
                uop.imm       = imm_u;
            end
            instr[6:0] == OP_AUIPC: begin
                uop.has_imm   = 1'b1;
                uop.reg_write = 1'b1;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_ADD;
                uop.rs1       = '0;
                uop.rs2       = '0;
                uop.imm       = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            uop.illegal    = 1'b1;
            uop.rd         = '0;
            uop.imm        = '0;
            uop.has_imm    = 1'b0;
            uop.reg_write  = 1'b0;
            uop.alu_src    = 1'b0;
            uop.branch     = 1'b0;
            uop.mem_read   = 1'b0;
            uop.mem_write  = 1'b0;
            uop.mem_to_reg = 1'b0;
            uop.alu_op     = ALU_ADD;
            uop.mem_size   = MEM_BYTE;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: DEPTH-entry instruction FIFO feeding a registered micro-op.
// Optional DECODE_QUEUE_BYPASS_EN decodes straight into the output when the FIFO is empty.
module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_has_imm,
    output logic             out_reg_write,
    output logic             out_alu_src,
    output logic             out_branch,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_mem_to_reg,
    output logic [1:0]       out_alu_op,
    output logic [1:0]       out_mem_size,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      instr_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty;
    logic             push, load, pop, bypass, fifo_push;
    logic [31:0]      dec_instr;
    logic [XLEN-1:0]  dec_pc;
    uop_t             dec_uop, uop_q;
    logic [2*XLEN_MAX-1:0] uop_unused;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign load     = (!out_valid || out_ready) && !flush;
    assign pop      = load && !empty;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass = load && empty && push;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = push && !bypass;
    assign dec_instr = bypass ? in_instr : instr_mem[rd_ptr];
    assign dec_pc    = bypass ? in_pc : pc_mem[rd_ptr];

    uop_decoder #(.XLEN(XLEN)) u_dec (
        .instr (dec_instr),
        .pc    (dec_pc),
        .uop   (dec_uop)
    );

    // FIFO storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // Pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(fifo_push) - CNT_W'(pop);
        end
    end

    // Output stage: load a new micro-op, drain when consumed, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uop_q     <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop || bypass) begin
            uop_q     <= dec_uop;
            out_valid <= 1'b1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

    assign uop_unused     = {uop_q.pc, uop_q.imm};
    assign out_pc         = uop_q.pc[XLEN-1:0];
    assign out_opcode     = uop_q.opcode;
    assign out_funct3     = uop_q.funct3;
    assign out_funct7     = uop_q.funct7;
    assign out_rs1        = uop_q.rs1;
    assign out_rs2        = uop_q.rs2;
    assign out_rd         = uop_q.rd;
    assign out_imm        = uop_q.imm[XLEN-1:0];
    assign out_has_imm    = uop_q.has_imm;
    assign out_reg_write  = uop_q.reg_write;
    assign out_alu_src    = uop_q.alu_src;
    assign out_branch     = uop_q.branch;
    assign out_mem_read   = uop_q.mem_read;
    assign out_mem_write  = uop_q.mem_write;
    assign out_mem_to_reg = uop_q.mem_to_reg;
    assign out_alu_op     = uop_q.alu_op;
    assign out_mem_size   = uop_q.mem_size;
    assign out_illegal    = uop_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed and randomized checks of decode_queue (XLEN=32, DEPTH=4).
// Random phase compares against a queue-level reference model.
module tb_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [6:0]       out_opcode;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0]  out_imm;
    logic             out_has_imm, out_reg_write, out_alu_src, out_branch;
    logic             out_mem_read, out_mem_write, out_mem_to_reg;
    logic [1:0]       out_alu_op, out_mem_size;
    logic             out_illegal;
    logic [CNT_W-1:0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    bit          mov;
    ent_t        mout;
    logic [6:0]  ops [0:10];

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_opcode     (out_opcode),
        .out_funct3     (out_funct3),
        .out_funct7     (out_funct7),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_rd         (out_rd),
        .out_imm        (out_imm),
        .out_has_imm    (out_has_imm),
        .out_reg_write  (out_reg_write),
        .out_alu_src    (out_alu_src),
        .out_branch     (out_branch),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_alu_op     (out_alu_op),
        .out_mem_size   (out_mem_size),
        .out_illegal    (out_illegal),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {out_has_imm, out_reg_write, out_alu_src, out_branch,
                out_mem_read, out_mem_write, out_mem_to_reg};
    endfunction

    // Reference decode written from the ISA tables: control string per opcode
    task automatic ref_decode(input logic [31:0] ins,
                              output logic [6:0] ctrl, output logic [1:0] alu,
                              output logic [1:0] ms, output logic [4:0] rs1,
                              output logic [4:0] rs2, output logic [4:0] rd,
                              output logic [31:0] imm, output bit ill);
        int v;
        bit mem;
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        rd  = ins[11:7];
        ill = 1'b0;
        mem = 1'b0;
        v   = 0;
        case (ins[6:0])
            7'h33: begin ctrl = 7'b0100000; alu = 2'd2; v = 0; end
            7'h13: begin ctrl = 7'b1110000; alu = 2'd2; v = i12; rs2 = 0; end
            7'h03: begin ctrl = 7'b1110101; alu = 2'd0; v = i12; rs2 = 0;
                         mem = 1'b1; ill = (ins[13:12] == 2'b11); end
            7'h23: begin ctrl = 7'b1010010; alu = 2'd0; v = s12; rd = 0;
                         mem = 1'b1; ill = (ins[13:12] == 2'b11); end
            7'h63: begin ctrl = 7'b1001000; alu = 2'd1; v = b13; rd = 0; end
            7'h6F: begin ctrl = 7'b1101000; alu = 2'd0; v = j21;
                         rs1 = 0; rs2 = 0; end
            7'h67: begin ctrl = 7'b1111000; alu = 2'd0; v = i12; rs2 = 0; end
            7'h37: begin ctrl = 7'b1110000; alu = 2'd3;
                         v = int'(ins[31:12]) * 4096; rs1 = 0; rs2 = 0; end
            7'h17: begin ctrl = 7'b1110000; alu = 2'd0;
                         v = int'(ins[31:12]) * 4096; rs1 = 0; rs2 = 0; end
            default: begin ctrl = 7'b0; alu = 2'd0; ill = 1'b1; end
        endcase
        imm = v;
        ms  = mem ? ins[13:12] : 2'b00;
        if (ill) begin
            ctrl = 7'b0;
            rd   = 0;
        end
    endtask

    // Compare every output field of the held micro-op against the reference
    task automatic check_uop(input string tag, input ent_t e);
        logic [6:0]  c;
        logic [1:0]  a, m;
        logic [4:0]  r1, r2, rdx;
        logic [31:0] im;
        bit          il;
        logic [107:0] ev, dv;
        ref_decode(e.instr, c, a, m, r1, r2, rdx, im, il);
        ev = {e.pc, e.instr[6:0], e.instr[14:12], e.instr[31:25],
              r1, r2, rdx, im, c, a, m, il};
        dv = {out_pc, out_opcode, out_funct3, out_funct7,
              out_rs1, out_rs2, out_rd, out_imm, dut_ctrl(),
              out_alu_op, out_mem_size, out_illegal};
        if (il) begin
            ev = {e.pc, e.instr[6:0], e.instr[14:12], e.instr[31:25],
                  5'd0, 5'd0, rdx, 32'd0, c, 2'd0, 2'd0, il};
            dv = {out_pc, out_opcode, out_funct3, out_funct7,
                  5'd0, 5'd0, out_rd, 32'd0, dut_ctrl(),
                  2'd0, 2'd0, out_illegal};
        end
        check(tag, 128'(dv), 128'(ev));
    endtask

    task automatic send_get(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 4) begin
            tick();
            n++;
        end
        check("send_timeout", 128'(out_valid), 128'(1));
    endtask

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_fields", 128'({out_pc, out_imm, out_rd, out_illegal,
              dut_ctrl(), out_alu_op}), 128'(0));
        tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));

        // addi x5,x1,-3: latency then fields
        in_valid  = 1'b1;
        in_instr  = 32'hFFD08293;
        in_pc     = 32'h100;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
        check("addi_lat1", 128'(out_valid), 128'(1));
`else
        check("addi_lat1", 128'(out_valid), 128'(0));
        check("addi_cnt1", 128'(count), 128'(1));
        tick();
        check("addi_lat2", 128'(out_valid), 128'(1));
`endif
        check("addi_regs", 128'({out_rd, out_rs1, out_rs2}),
              128'({5'd5, 5'd1, 5'd0}));
        check("addi_imm", 128'(out_imm), 128'(32'hFFFFFFFD));
        check("addi_ctl", 128'({out_alu_op, out_reg_write, out_pc}),
              128'({2'b10, 1'b1, 32'h100}));
        tick();
        check("addi_drain", 128'({out_valid, count}), 128'(0));

        // Back-pressure: five pushes, four queued behind the output stage
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = 32'hFFD08293;
            in_pc    = 32'h200 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        check("bp_full", 128'({in_ready, count, out_valid}),
              128'({1'b0, 3'd4, 1'b1}));
        check("bp_head", 128'(out_pc), 128'(32'h200));
        tick();
        check("bp_hold", 128'({out_pc, count}), 128'({32'h200, 3'd4}));
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            check("bp_order", 128'({out_valid, out_pc, count}),
                  128'({1'b1, 32'h200 + 32'(4 * i), 3'(4 - i)}));
        end
        tick();
        check("bp_empty", 128'(out_valid), 128'(0));

        // Store, load-byte, branch and illegal encodings
        send_get(32'h0020A423, 32'h140);
        check("sw_fields", 128'({out_rd, out_rs2, out_imm}),
              128'({5'd0, 5'd2, 32'd8}));
        check("sw_ctl", 128'({out_mem_write, out_mem_size, out_reg_write}),
              128'({1'b1, 2'b10, 1'b0}));
        out_ready = 1'b1;
        tick();
        send_get(32'h00408183, 32'h144);
        check("lb_ctl", 128'({out_mem_size, out_mem_read, out_mem_to_reg}),
              128'({2'b00, 1'b1, 1'b1}));
        check("lb_fields", 128'({out_rd, out_imm}), 128'({5'd3, 32'd4}));
        out_ready = 1'b1;
        tick();
        send_get(32'hFE000EE3, 32'h148);
        check("beq_imm", 128'(out_imm), 128'(32'hFFFFFFFC));
        check("beq_ctl", 128'({out_branch, out_alu_op, out_rd}),
              128'({1'b1, 2'b01, 5'd0}));
        out_ready = 1'b1;
        tick();
        send_get(32'h123456FF, 32'h14C);
        check("ill_flag", 128'({out_illegal, dut_ctrl(), out_rd}),
              128'({1'b1, 7'd0, 5'd0}));
        check("ill_raw", 128'({out_opcode, out_pc}),
              128'({7'h7F, 32'h14C}));
        out_ready = 1'b1;
        tick();

        // Flush with a simultaneous push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h00000013;
            in_pc    = 32'h300 + 32'(4 * i);
            tick();
        end
        check("fl_pre", 128'({count, out_valid}), 128'({3'd3, 1'b1}));
        flush = 1'b1;
        in_pc = 32'h400;
        #1;
        check("fl_ready", 128'(in_ready), 128'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_post", 128'({count, out_valid}), 128'(0));
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_drop", 128'({count, out_valid}), 128'(0));

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h00000013;
            in_pc    = 32'h500 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        check("ar_pre", 128'({count, out_valid}), 128'({3'd2, 1'b1}));
        #2 rst = 1'b1;
        #1;
        check("ar_clear", 128'({count, out_valid, out_pc}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_ready", 128'(in_ready), 128'(1));

        // Randomized traffic against the queue-level model
        mov = 1'b0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            bit   iv, orr, acc, cons, byp;
            ent_t e;
            int   k;
            k = $urandom_range(0, 10);
            e.instr = {$urandom() & 32'hFFFFFF80} | 32'(ops[k]);
            if (k == 10) e.instr[1:0] = 2'($urandom_range(0, 2));
            e.pc = $urandom() & 32'hFFFFFFFC;
            iv  = ($urandom_range(0, 99) < 60);
            orr = ($urandom_range(0, 99) < 60);
            in_valid  = iv;
            in_instr  = e.instr;
            in_pc     = e.pc;
            out_ready = orr;
            #1;
            check("rnd_in_ready", 128'(in_ready),
                  128'(q.size() < DEPTH));
            tick();
            acc  = iv && (q.size() < DEPTH);
            cons = !mov || orr;
            byp  = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
            byp = cons && (q.size() == 0) && acc;
`endif
            if (byp) begin
                mov  = 1'b1;
                mout = e;
                acc  = 1'b0;
            end else if (cons) begin
                if (q.size() > 0) begin
                    mout = q.pop_front();
                    mov  = 1'b1;
                end else begin
                    mov = 1'b0;
                end
            end
            if (acc) q.push_back(e);
            check("rnd_valid", 128'(out_valid), 128'(mov));
            check("rnd_count", 128'(count), 128'(q.size()));
            if (mov) check_uop("rnd_uop", mout);
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
